// File: rtl/gameconsole_pkg.sv
// Shared console constants: screen geometry, line-buffer widths and pixel word layout.
package gameconsole_pkg;
  localparam int SCREEN_W        = 256;
  localparam int SCREEN_H        = 240;
  localparam int HMAX            = 341;
  localparam int VMAX            = 262;
  localparam int CLK_PER_DOT     = 4;
  localparam int LINEBUFF_ADDR_W = 8;
  localparam int LINEBUFF_DATA_W = 32;
  localparam int PIX_OPAQUE_BIT  = 31;
  localparam int PIX_PRIO_BIT    = 30;
  localparam int PIX_RGB_W       = 24;

  typedef enum logic {ST_WAIT = 1'b0, ST_RUN = 1'b1} scan_state_e;
endpackage

// File: rtl/vpu_sync_gen.sv
// Registered active-low hsync/vsync from the dot/line position of the shared timebase.
module vpu_sync_gen #(
  parameter int H_START = 264,
  parameter int H_LEN   = 32,
  parameter int H_TOTAL = 341,
  parameter int V_START = 242,
  parameter int V_LEN   = 2,
  parameter int V_TOTAL = 262
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [8:0] x,
  input  logic [8:0] y,
  input  logic       dot_start,
  input  logic       line_start,
  output logic       hsync,
  output logic       vsync
);
  // Windows running past the line/frame end are cut short rather than wrapped.
  localparam int H_END = (H_START + H_LEN > H_TOTAL) ? H_TOTAL : H_START + H_LEN;
  localparam int V_END = (V_START + V_LEN > V_TOTAL) ? V_TOTAL : V_START + V_LEN;
  localparam logic [9:0] H_LO = 10'(H_START);
  localparam logic [9:0] H_HI = 10'(H_END);
  localparam logic [9:0] V_LO = 10'(V_START);
  localparam logic [9:0] V_HI = 10'(V_END);

  logic in_h, in_v;
  assign in_h = ({1'b0, x} >= H_LO) && ({1'b0, x} < H_HI);
  assign in_v = ({1'b0, y} >= V_LO) && ({1'b0, y} < V_HI);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hsync <= 1'b1;
      vsync <= 1'b1;
    end else begin
      if (dot_start)  hsync <= !in_h;
      if (line_start) vsync <= !in_v;
    end
  end
endmodule

// File: rtl/vpu_scanout.sv
// VPU display back-end: reads BG/SP line buffers, composites by priority/opacity,
// emits registered color, dot clock and sync, and clears the displayed SP bank.
module vpu_scanout
  import gameconsole_pkg::*;
#(
  parameter int SCREEN_W      = gameconsole_pkg::SCREEN_W,
  parameter int SCREEN_H      = gameconsole_pkg::SCREEN_H,
  parameter int HMAX          = gameconsole_pkg::HMAX,
  parameter int VMAX          = gameconsole_pkg::VMAX,
  parameter int HSYNC_START   = 8,
  parameter int HSYNC_LEN     = 32,
  parameter int VSYNC_START   = 2,
  parameter int VSYNC_LEN     = 2,
  parameter int CLEAR_ON_READ = 1
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic [10:0]                line_cycle,
  input  logic [8:0]                 y,
  output logic [LINEBUFF_ADDR_W-1:0] bg_rd_addr,
  input  logic [LINEBUFF_DATA_W-1:0] bg_rd_data,
  output logic                       sp_bank,
  output logic [LINEBUFF_ADDR_W-1:0] sp_rd_addr,
  input  logic [LINEBUFF_DATA_W-1:0] sp_rd_data,
  output logic                       sp_we,
  input  logic [23:0]                backdrop,
  output logic                       dot_clk,
  output logic [31:0]                color,
  output logic                       hsync,
  output logic                       vsync
);
  localparam int PH_W = $clog2(CLK_PER_DOT);
  localparam int XW   = 11 - PH_W;
  localparam logic [XW-1:0] X_SW   = XW'(SCREEN_W);
  localparam logic [XW-1:0] X_LAST = XW'(HMAX - 1);
  localparam logic [8:0]    Y_SH   = 9'(SCREEN_H);
  localparam logic [LINEBUFF_ADDR_W-1:0] ADDR_LAST = LINEBUFF_ADDR_W'(SCREEN_W - 1);
  localparam logic [PH_W-1:0] PH_DATA = PH_W'(1);
  localparam logic [PH_W-1:0] PH_OUT  = PH_W'(2);
  localparam logic [PH_W-1:0] PH_ADDR = PH_W'(CLK_PER_DOT - 1);

  function automatic logic [PIX_RGB_W-1:0] composite(
    input logic [LINEBUFF_DATA_W-1:0] bg,
    input logic [LINEBUFF_DATA_W-1:0] sp,
    input logic [23:0]                bd
  );
    if (sp[PIX_OPAQUE_BIT] && (sp[PIX_PRIO_BIT] || !bg[PIX_OPAQUE_BIT]))
      return sp[PIX_RGB_W-1:0];
    else if (bg[PIX_OPAQUE_BIT])
      return bg[PIX_RGB_W-1:0];
    return bd;
  endfunction

  scan_state_e               state;
  logic [XW-1:0]             x, nx;
  logic [PH_W-1:0]           ph;
  logic                      active, run;
  logic [LINEBUFF_ADDR_W-1:0] addr_nx;
  logic [PIX_RGB_W-1:0]      staging_p1;

  assign x       = line_cycle[10:PH_W];
  assign ph      = line_cycle[PH_W-1:0];
  assign active  = (x < X_SW) && (y < Y_SH);
  assign run     = (state == ST_RUN);
  assign sp_bank = ~y[0];
  // Address for the next dot is set up on the last phase so it is stable for the whole of ph0.
  assign nx      = (x == X_LAST) ? '0 : x + 1'b1;
  assign addr_nx = (nx < X_SW) ? nx[LINEBUFF_ADDR_W-1:0] : ADDR_LAST;

  // Stage p1: line-buffer data valid, composite into staging.
  always_ff @(posedge clk) begin
    if (ph == PH_DATA)
      staging_p1 <= composite(bg_rd_data, sp_rd_data, backdrop);
  end

  // Stage p2: FSM, output color, dot clock, clear strobe and read addresses.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= ST_WAIT;
      color      <= '0;
      dot_clk    <= 1'b0;
      sp_we      <= 1'b0;
      bg_rd_addr <= '0;
      sp_rd_addr <= '0;
    end else begin
      case (state)
        ST_WAIT: if (line_cycle == 11'd0 && y == 9'd0) state <= ST_RUN;
        default: state <= ST_RUN;
      endcase
      sp_we   <= (CLEAR_ON_READ != 0) && run && active && (ph == PH_DATA);
      dot_clk <= run && (ph >= PH_OUT);
      if (ph == PH_OUT)
        color <= (run && active) ? {8'h00, staging_p1} : 32'h0;
      if (ph == PH_ADDR) begin
        bg_rd_addr <= addr_nx;
        sp_rd_addr <= addr_nx;
      end
    end
  end

  vpu_sync_gen #(
    .H_START(SCREEN_W + HSYNC_START),
    .H_LEN  (HSYNC_LEN),
    .H_TOTAL(HMAX),
    .V_START(SCREEN_H + VSYNC_START),
    .V_LEN  (VSYNC_LEN),
    .V_TOTAL(VMAX)
  ) u_sync (
    .clk       (clk),
    .rst_n     (rst_n),
    .x         (x),
    .y         (y),
    .dot_start (ph == '0),
    .line_start(line_cycle == 11'd0),
    .hsync     (hsync),
    .vsync     (vsync)
  );
endmodule

// File: tb/tb_vpu_scanout.sv
// Directed bench for vpu_scanout on a shrunken 16x6 screen inside a 64x12 raster.
module tb_vpu_scanout;
  import gameconsole_pkg::*;

  localparam int SW = 16, SH = 6, HM = 64, VM = 12;
  localparam int LC_MAX = HM * 4 - 1;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n = 1'b1;
  logic [10:0] lc = 11'd100;
  logic [8:0]  y = 9'd3;
  logic [23:0] backdrop = 24'h0000FF;
  logic [LINEBUFF_ADDR_W-1:0] bg_rd_addr, sp_rd_addr;
  logic [31:0] bg_q = '0, sp_q = '0, color;
  logic        sp_bank, sp_we, dot_clk, hsync, vsync;

  logic [31:0] bg_mem [0:255];
  logic [31:0] sp_mem [0:1][0:255];

  vpu_scanout #(
    .SCREEN_W(SW), .SCREEN_H(SH), .HMAX(HM), .VMAX(VM),
    .HSYNC_START(8), .HSYNC_LEN(32), .VSYNC_START(2), .VSYNC_LEN(2),
    .CLEAR_ON_READ(1)
  ) dut (
    .clk(clk), .rst_n(rst_n), .line_cycle(lc), .y(y),
    .bg_rd_addr(bg_rd_addr), .bg_rd_data(bg_q),
    .sp_bank(sp_bank), .sp_rd_addr(sp_rd_addr), .sp_rd_data(sp_q),
    .sp_we(sp_we), .backdrop(backdrop), .dot_clk(dot_clk),
    .color(color), .hsync(hsync), .vsync(vsync)
  );

  // Line-buffer models: 1-cycle read latency, SP clear on sp_we.
  always @(posedge clk) begin
    bg_q <= bg_mem[bg_rd_addr];
    sp_q <= sp_mem[sp_bank][sp_rd_addr];
    if (sp_we) sp_mem[sp_bank][sp_rd_addr] = '0;
  end

  int total = 0, bad = 0;
  int frame = 0, hs_cnt = 0, vs_lines = 0, vs_cyc = 0;
  int we_cnt = 0, we_err = 0, wait_err = 0, dc_err = 0, nz;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%h expected=%h (y=%0d lc=%0d)", tag, got, exp, y, lc);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
    if (lc == 11'(LC_MAX)) begin
      lc = 11'd0;
      y  = (y == 9'(VM - 1)) ? 9'd0 : y + 9'd1;
    end else begin
      lc = lc + 11'd1;
    end
    if (rst_n && lc == 11'd0 && y == 9'd0) frame++;
    if (frame == 0 && (color !== 32'h0 || dot_clk !== 1'b0 || sp_we !== 1'b0)) wait_err++;

    if (lc == 11'd0) begin
      if (frame >= 1) chk("hsync_low_clks", 32'(hs_cnt), 32'd128);
      hs_cnt = 0;
      if (frame == 1 && y == 9'd1) begin
        chk("sp_we_pulses", 32'(we_cnt), 32'(SW));
        chk("sp_we_timing", 32'(we_err), 32'd0);
        chk("dot_clk_pattern", 32'(dc_err), 32'd0);
      end
      if (frame == 1 && y == 9'd7) chk("sp_we_blank_line", 32'(we_cnt), 32'd0);
      we_cnt = 0;
      we_err = 0;
      if (y == 9'd0) begin
        if (frame >= 2) begin
          chk("vsync_low_lines", 32'(vs_lines), 32'd2);
          chk("vsync_low_clks", 32'(vs_cyc), 32'd512);
        end
        vs_lines = 0;
        vs_cyc = 0;
      end
    end
    if (hsync == 1'b0) hs_cnt++;
    if (vsync == 1'b0) vs_cyc++;
    if (lc == 11'd1 && vsync == 1'b0) vs_lines++;
    if (sp_we) begin
      we_cnt++;
      if (lc[1:0] != 2'd2 || sp_rd_addr != 8'(lc >> 2) || sp_bank != ~y[0]) we_err++;
    end
    if (frame == 1 && y == 9'd0 && lc >= 11'd1)
      if (dot_clk !== (lc[1:0] == 2'd3 || lc[1:0] == 2'd0)) dc_err++;

    if (frame == 1) begin
      if (y == 9'd0) begin
        case (lc)
          11'd22:  chk("x4_backdrop", color, 32'h000000FF);
          11'd23:  chk("x5_bg_first", color, 32'h00112233);
          11'd24:  chk("x5_bg_hold1", color, 32'h00112233);
          11'd25:  chk("x5_bg_hold2", color, 32'h00112233);
          11'd26:  chk("x5_bg_last", color, 32'h00112233);
          11'd31:  chk("x7_backdrop", color, 32'h000000FF);
          11'd63:  chk("x15_last_active", color, 32'h000000FF);
          11'd67:  chk("x16_blank", color, 32'h0);
          11'd96:  chk("hsync_before", 32'(hsync), 32'd1);
          11'd97:  chk("hsync_start", 32'(hsync), 32'd0);
          11'd224: chk("hsync_end", 32'(hsync), 32'd0);
          11'd225: chk("hsync_after", 32'(hsync), 32'd1);
          default: ;
        endcase
      end
      if (y == 9'd1) begin
        if (lc == 11'd5) chk("sp_bank_line1", 32'(sp_bank), 32'd0);
        if (lc == 11'd10) begin
          nz = 0;
          for (int i = 0; i < SW; i++) if (sp_mem[1][i] != 32'h0) nz++;
          chk("bank1_cleared", 32'(nz), 32'd0);
          sp_mem[1][5] = 32'h80AABBCC;
        end
        if (lc == 11'd23) chk("x5_sp_prio", color, 32'h00AABBCC);
        if (lc == 11'd31) chk("x7_sp_over_clear_bg", color, 32'h00445566);
      end
      if (y == 9'd2 && lc == 11'd23) chk("x5_sp_no_prio", color, 32'h00112233);
      if (y == 9'd6 && lc == 11'd23) chk("y6_blank", color, 32'h0);
    end
  endtask

  initial begin
    int guard = 0;
    for (int i = 0; i < 256; i++) begin
      bg_mem[i] = '0;
      sp_mem[0][i] = '0;
      sp_mem[1][i] = 32'h3F000000 | 32'(i);
    end
    bg_mem[5]    = 32'h80112233;
    sp_mem[1][5] = '0;
    sp_mem[1][7] = '0;
    sp_mem[0][5] = 32'hC0AABBCC;
    sp_mem[0][7] = 32'h80445566;

    #3 rst_n = 1'b0;
    #1;
    chk("rst_color", color, 32'h0);
    chk("rst_hsync", 32'(hsync), 32'd1);
    chk("rst_vsync", 32'(vsync), 32'd1);
    chk("rst_dot_clk", 32'(dot_clk), 32'd0);
    chk("rst_sp_we", 32'(sp_we), 32'd0);
    chk("rst_bg_addr", 32'(bg_rd_addr), 32'd0);
    chk("rst_sp_addr", 32'(sp_rd_addr), 32'd0);
    repeat (3) step();
    rst_n = 1'b1;

    while (frame < 3 && guard < 20000) begin
      step();
      guard++;
    end
    chk("frames_reached", 32'(frame), 32'd3);
    chk("wait_blanking", 32'(wait_err), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
